// File: rtl/gpio_input_ctrl.sv
// Purpose : synchronise, debounce and edge-detect GPIO pad inputs into sticky per-pin IRQ flags.
// Latency : a steady pad level reaches gpio_in_data (and sets irq_pending) on edge SYNC_STAGES+DEBOUNCE_CYCLES.
// Backpressure: none; the pads are sampled every cycle and the pending bits hold events until cleared.
//
// Ports:
//   clk, reset      master clock, synchronous active-high reset
//   gpio_pin_in     raw pad levels, asynchronous to clk
//   gpio_ts         per-pin tristate control (1 = pin driven as output)
//   irq_en          per-pin interrupt enable
//   irq_rise_en     per-pin enable for debounced 0->1 transitions
//   irq_fall_en     per-pin enable for debounced 1->0 transitions
//   irq_clr         per-pin write-1-to-clear pulse for irq_pending
//   gpio_in_data    debounced, synchronised pin levels (registered)
//   irq_pending     sticky per-pin edge flags (registered)
//   irq             OR of irq_pending
module gpio_input_ctrl #(
   parameter int WIDTH           = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] gpio_pin_in,
   input  logic [WIDTH-1:0] gpio_ts,
   input  logic [WIDTH-1:0] irq_en,
   input  logic [WIDTH-1:0] irq_rise_en,
   input  logic [WIDTH-1:0] irq_fall_en,
   input  logic [WIDTH-1:0] irq_clr,
   output logic [WIDTH-1:0] gpio_in_data,
   output logic [WIDTH-1:0] irq_pending,
   output logic             irq
);

   // Count value at which a differing level has been held long enough.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
   logic [WIDTH-1:0] sync_lvl;
   logic [WIDTH-1:0] stable_q;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [WIDTH-1:0] upd;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] set_pend;
   logic [WIDTH-1:0] pend_q;

   // Metastability synchroniser: one shift chain per pin, all pins side by side.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_chain[s] <= '0;
         end
      end else begin
         sync_chain[0] <= gpio_pin_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_chain[s] <= sync_chain[s-1];
         end
      end
   end

   assign sync_lvl = sync_chain[SYNC_STAGES-1];

   // A pin updates when it has differed from the stable level for
   // DEBOUNCE_CYCLES consecutive edges, this edge included.
   always_comb begin
      upd = '0;
      for (int i = 0; i < WIDTH; i++) begin
         upd[i] = (sync_lvl[i] != stable_q[i]) && (cnt_q[i] == CNT_LAST);
      end
   end

   // Debounce counters and stable levels. The counter only advances while the
   // level differs and is cleared on the terminal count, so it never wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_q <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync_lvl[i] == stable_q[i]) begin
               cnt_q[i] <= '0;
            end else if (upd[i]) begin
               stable_q[i] <= sync_lvl[i];
               cnt_q[i]    <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Edge detect on the debounced level; output pins never raise interrupts.
   assign rise     = upd & sync_lvl;
   assign fall     = upd & ~sync_lvl;
   assign set_pend = irq_en & ~gpio_ts & ((rise & irq_rise_en) | (fall & irq_fall_en));

   // Sticky pending bits: a new event on the same edge as a clear wins, so no
   // event is lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q <= '0;
      end else begin
         pend_q <= (pend_q & ~irq_clr) | set_pend;
      end
   end

   assign gpio_in_data = stable_q;
   assign irq_pending  = pend_q;
   assign irq          = |pend_q;

endmodule

// File: tb/tb_gpio_input_ctrl.sv
// Purpose : directed self-checking bench for gpio_input_ctrl at default parameters.
// Latency : expects a steady pad level to appear on the 6th edge after it is applied.
// Backpressure: none; inputs are driven 1 time unit after each rising edge.
module tb_gpio_input_ctrl;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] gpio_pin_in;
   logic [WIDTH-1:0] gpio_ts;
   logic [WIDTH-1:0] irq_en;
   logic [WIDTH-1:0] irq_rise_en;
   logic [WIDTH-1:0] irq_fall_en;
   logic [WIDTH-1:0] irq_clr;
   logic [WIDTH-1:0] gpio_in_data;
   logic [WIDTH-1:0] irq_pending;
   logic             irq;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   gpio_input_ctrl #(
      .WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .gpio_pin_in  (gpio_pin_in),
      .gpio_ts      (gpio_ts),
      .irq_en       (irq_en),
      .irq_rise_en  (irq_rise_en),
      .irq_fall_en  (irq_fall_en),
      .irq_clr      (irq_clr),
      .gpio_in_data (gpio_in_data),
      .irq_pending  (irq_pending),
      .irq          (irq)
   );

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
      end
   endtask

   initial begin
      reset       = 1'b1;
      gpio_pin_in = '0;
      gpio_ts     = 16'h0080;  // pin7 is an output
      irq_en      = 16'hFFFF;
      irq_rise_en = 16'hFFDF;  // pin5 flags falls only
      irq_fall_en = 16'h00A0;  // pins 5 and 7
      irq_clr     = '0;

      // Reset state
      step(2);
      check("rst_data", gpio_in_data, 16'h0000);
      check("rst_pend", irq_pending, 16'h0000);
      check("rst_irq", {15'd0, irq}, 16'h0000);
      reset = 1'b0;

      // Pin0 rise: visible exactly on edge 6, with pending and irq
      gpio_pin_in[0] = 1'b1;
      step(5);
      check("p0_edge5_data", gpio_in_data, 16'h0000);
      check("p0_edge5_pend", irq_pending, 16'h0000);
      step(1);
      check("p0_edge6_data", gpio_in_data, 16'h0001);
      check("p0_edge6_pend", irq_pending, 16'h0001);
      check("p0_edge6_irq", {15'd0, irq}, 16'h0001);
      irq_clr = 16'h0001;
      step(1);
      irq_clr = '0;
      check("p0_clr_pend", irq_pending, 16'h0000);
      check("p0_clr_irq", {15'd0, irq}, 16'h0000);

      // Pin3 glitch of 3 cycles is rejected
      gpio_pin_in[3] = 1'b1;
      step(3);
      gpio_pin_in[3] = 1'b0;
      step(8);
      check("p3_glitch_data", gpio_in_data, 16'h0001);
      check("p3_glitch_pend", irq_pending, 16'h0000);

      // Pin5: rise not flagged, fall flagged, clear, rise not flagged
      gpio_pin_in[5] = 1'b1;
      step(6);
      check("p5_rise_data", gpio_in_data, 16'h0021);
      check("p5_rise_pend", irq_pending, 16'h0000);
      gpio_pin_in[5] = 1'b0;
      step(5);
      check("p5_fall_e5_pend", irq_pending, 16'h0000);
      step(1);
      check("p5_fall_data", gpio_in_data, 16'h0001);
      check("p5_fall_pend", irq_pending, 16'h0020);
      check("p5_fall_irq", {15'd0, irq}, 16'h0001);
      irq_clr = 16'h0020;
      step(1);
      irq_clr = '0;
      check("p5_clr_pend", irq_pending, 16'h0000);
      gpio_pin_in[5] = 1'b1;
      step(8);
      check("p5_rerise_data", gpio_in_data, 16'h0021);
      check("p5_rerise_pend", irq_pending, 16'h0000);

      // Pin2: set pending, fall (not enabled) keeps it, clear collides with new rise
      gpio_pin_in[2] = 1'b1;
      step(6);
      check("p2_rise_pend", irq_pending, 16'h0004);
      gpio_pin_in[2] = 1'b0;
      step(6);
      check("p2_fall_data", gpio_in_data, 16'h0021);
      check("p2_fall_pend", irq_pending, 16'h0004);
      gpio_pin_in[2] = 1'b1;
      step(5);
      irq_clr = 16'h0004;
      step(1);
      irq_clr = '0;
      check("p2_setclr_data", gpio_in_data, 16'h0025);
      check("p2_setclr_pend", irq_pending, 16'h0004);
      irq_clr = 16'h0004;
      step(1);
      irq_clr = '0;
      check("p2_clr_pend", irq_pending, 16'h0000);

      // Pin7 driven as output: readback follows, never pending
      gpio_pin_in[7] = 1'b1;
      step(5);
      check("p7_rise_e5_data", gpio_in_data, 16'h0025);
      step(1);
      check("p7_rise_data", gpio_in_data, 16'h00A5);
      check("p7_rise_pend", irq_pending, 16'h0000);
      gpio_pin_in[7] = 1'b0;
      step(6);
      check("p7_fall_data", gpio_in_data, 16'h0025);
      check("p7_fall_pend", irq_pending, 16'h0000);

      // Pin9: reset two cycles into its debounce, then full latency restarts
      gpio_pin_in[9] = 1'b1;
      step(2);
      reset = 1'b1;
      step(1);
      check("p9_rst_data", gpio_in_data, 16'h0000);
      check("p9_rst_pend", irq_pending, 16'h0000);
      check("p9_rst_irq", {15'd0, irq}, 16'h0000);
      reset = 1'b0;
      step(5);
      check("p9_rel_e5_data", gpio_in_data, 16'h0000);
      check("p9_rel_e5_pend", irq_pending, 16'h0000);
      step(1);
      check("p9_rel_data", gpio_in_data, 16'h0225);
      check("p9_rel_pend", irq_pending, 16'h0205);
      check("p9_rel_irq", {15'd0, irq}, 16'h0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
